bm1387_result_collector: RTL and testbench
==========================================

# bm1387_result_collector

Downstream consumer of the `bm1387_asic` mining interface. It captures each result the ASIC presents on `hash_valid`/`found_nonce`/`found_hash` and grades it by leading-zero count against a runtime share target. Qualifying shares are buffered in a FIFO behind a valid/ready port for the host-side reporter. Share statistics are also kept for the debug and telemetry path.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8. Result FIFO entries; power of 2, minimum 2.
- `CNT_W`, default 32. Width of the accepted and rejected share counters.

Ports:
- `clk_100m` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `hash_valid` in 1: ASIC result-present level.
- `found_nonce` in 32: ASIC result nonce.
- `found_hash` in 256: ASIC result hash; bit 255 is the MSB.
- `target_zeros` in 8: minimum leading-zero bits for a share; sampled at grading.
- `flush` in 1: synchronous clear of pipeline, FIFO and `overflow`.
- `res_valid` out 1: FIFO head is valid.
- `res_ready` in 1: consumer accepts the head.
- `res_nonce` out 32: head nonce.
- `res_zeros` out 9: head leading-zero count, 0..256.
- `res_hash` out 256: head hash.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: occupancy.
- `shares_accepted` out CNT_W: saturating count.
- `shares_rejected` out CNT_W: saturating count of results below target.
- `shares_dropped` out 16: saturating count of accepted shares lost because the FIFO was full.
- `overflow` out 1: sticky; set on any drop.

## Operation
- Reset value of every output is 0. This includes `res_valid`, `fifo_count`, all counters, `overflow`, and the head data buses.
- Capture event on a rising edge of `clk_100m` when either condition holds:
  - `hash_valid`=1 and the previously sampled `hash_valid`=0, or
  - `hash_valid`=1 and `found_nonce` differs from the last captured nonce.
- A `hash_valid` level held high with an unchanged nonce yields exactly one event.
- Stage S1 registers nonce and hash plus an S1-valid bit.
- Stage S2 is combinational from S1:
  - Leading-zero count `z` is measured from bit 255 down; an all-zero hash gives `z`=256.
  - Accept iff `z` >= `target_zeros`, zero-extended to 9 bits. An all-zero hash is therefore always accepted.
- On the edge following S1-valid, exactly one of these occurs:
  - Rejected: increment `shares_rejected`.
  - Accepted with space: push to FIFO and increment `shares_accepted`.
  - Accepted but full: increment `shares_accepted` and `shares_dropped`, and set `overflow`.
- Space is evaluated after the same-cycle pop. Full plus push plus pop is legal; both happen and occupancy is unchanged.
- Pop occurs when `res_valid` && `res_ready`. The head outputs are held stable while `res_valid`=1 && `res_ready`=0.
- `flush` applies at the next edge:
  - empties the FIFO (`res_valid`=0, `fifo_count`=0),
  - clears S1-valid, discarding both the event in S1 and any event capturing that cycle,
  - clears `overflow`.
- `flush` outranks push and pop in the same cycle. Counters are not cleared by `flush`.
- The edge detector and the last-captured-nonce register keep updating during `flush`. A level still high afterwards is not re-captured.
- All counters saturate at all-ones and never wrap.
- `reset` asserted mid-operation immediately clears everything, including the edge-detector history.

## Timing
- Event sampled at edge N: S1 loaded at N; FIFO push and counter update at N+1.
- `res_valid` rises after N+1 when the FIFO was empty. There is no bypass path. Minimum latency is 2 cycles.
- Back-to-back events, one per cycle, are sustained without loss while the FIFO has space.
- `fifo_count` and `res_valid` update on the same edge as the push or pop.
- `target_zeros` is used in the cycle S1 is graded, not at capture.

## Structure
- Shared package `bm1387_pkg` holds:
  - constants `NONCE_W`=32, `HASH_W`=256, `ZCNT_W`=9,
  - typedef `bm1387_result_t` {nonce, zeros, hash}.
- Sub-module `bm1387_result_fifo`: synchronous FIFO of `bm1387_result_t`, with push, pop and flush, plus full, empty and count outputs.
- The leading-zero counter is a function in `bm1387_pkg`.

## Test plan
- Hold `hash_valid`=1 for 10 cycles with nonce 0x1000, hash 0x00FF<<240, `target_zeros`=8 → exactly one entry with `res_zeros`=8 and `shares_accepted`=1; `res_valid` rises 2 cycles after the edge.
- Same setup but hash 0x01<<248 and `target_zeros`=8 → `z`=7, `shares_rejected`=1, FIFO stays empty. All-zero hash with `target_zeros`=255 → accepted with `res_zeros`=256.
- `res_ready`=0 and 10 accepted nonces 0x2000..0x2009 at one per cycle with DEPTH 8 → `fifo_count`=8, `shares_dropped`=2, `overflow`=1. Draining then yields nonces 0x2000..0x2007 in order.
- FIFO full with `res_ready`=1 and a push arriving the same cycle → no drop, `fifo_count` stays 8.
- `flush` pulsed with 4 queued entries plus one event in S1 → next cycle `res_valid`=0, `fifo_count`=0, `overflow`=0; counters unchanged; the S1 event is never pushed.
- `reset` asserted between events, mid-cycle → all outputs 0 immediately. After release, a still-high `hash_valid` is captured as a new event.

Source files
------------

// File: rtl/bm1387_pkg.sv
// Shared types, widths and the leading-zero helper for the BM1387 result path.
package bm1387_pkg;

    localparam int NONCE_W = 32;
    localparam int HASH_W  = 256;
    localparam int ZCNT_W  = 9;

    typedef struct packed {
        logic [NONCE_W-1:0] nonce;
        logic [ZCNT_W-1:0]  zeros;
        logic [HASH_W-1:0]  hash;
    } bm1387_result_t;

    // Leading zeros counted from bit 255 downward; an all-zero hash yields 256.
    function automatic logic [ZCNT_W-1:0] lead_zeros(input logic [HASH_W-1:0] h);
        logic [ZCNT_W-1:0] z;
        logic              seen;
        z    = '0;
        seen = 1'b0;
        for (int i = HASH_W - 1; i >= 0; i--) begin
            if (h[i]) begin
                seen = 1'b1;
            end else if (!seen) begin
                z = z + 9'd1;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/bm1387_result_collector_if.sv
// Host-side result port: valid/ready handshake plus the FIFO head fields.
interface bm1387_result_collector_if;
    import bm1387_pkg::*;

    logic               res_valid;
    logic               res_ready;
    logic [NONCE_W-1:0] res_nonce;
    logic [ZCNT_W-1:0]  res_zeros;
    logic [HASH_W-1:0]  res_hash;

    modport master (
        output res_valid,
        output res_nonce,
        output res_zeros,
        output res_hash,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_nonce,
        input  res_zeros,
        input  res_hash,
        output res_ready
    );

endinterface

// File: rtl/bm1387_result_fifo.sv
// Synchronous FIFO of graded results. Flush outranks push and pop; a push
// into a full FIFO is taken only when a pop frees a slot in the same cycle.
module bm1387_result_fifo
    import bm1387_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  bm1387_result_t         wr_data,
    output bm1387_result_t         rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    bm1387_result_t mem_q [DEPTH];

    logic do_pop;
    logic do_push;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero while empty so the output buses read 0 out of reset.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    // Storage array; contents are only observed through the empty-gated head.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/bm1387_result_collector.sv
// Captures BM1387 results, grades them by leading zeros against the share
// target, queues qualifying shares and keeps saturating share statistics.
module bm1387_result_collector
    import bm1387_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic                        clk_100m,
    input  logic                        reset,
    input  logic                        hash_valid,
    input  logic [NONCE_W-1:0]          found_nonce,
    input  logic [HASH_W-1:0]           found_hash,
    input  logic [7:0]                  target_zeros,
    input  logic                        flush,
    bm1387_result_collector_if.master   res,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]            shares_accepted,
    output logic [CNT_W-1:0]            shares_rejected,
    output logic [15:0]                 shares_dropped,
    output logic                        overflow
);

    logic               hv_q;
    logic [NONCE_W-1:0] last_nonce_q;
    logic               s1_valid_q;
    logic [NONCE_W-1:0] s1_nonce_q;
    logic [HASH_W-1:0]  s1_hash_q;

    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   rej_q, rej_d;
    logic [15:0]        drop_q, drop_d;
    logic               ovf_q, ovf_d;

    logic               capture;
    logic [ZCNT_W-1:0]  s1_zeros;
    logic               s1_accept;
    logic               graded;
    logic               pop;
    logic               push;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    bm1387_result_t     push_data;
    bm1387_result_t     head;

    // A new result is either a rising hash_valid or a changed nonce under a held level.
    assign capture = hash_valid && (!hv_q || (found_nonce != last_nonce_q));

    // Edge history keeps tracking through flush so a held level is not re-captured.
    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            hv_q         <= 1'b0;
            last_nonce_q <= '0;
        end else begin
            hv_q <= hash_valid;
            if (capture) begin
                last_nonce_q <= found_nonce;
            end
        end
    end

    // S1 capture register; flush discards both the resident and the arriving event.
    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_nonce_q <= '0;
            s1_hash_q  <= '0;
        end else begin
            s1_valid_q <= capture && !flush;
            if (capture) begin
                s1_nonce_q <= found_nonce;
                s1_hash_q  <= found_hash;
            end
        end
    end

    assign s1_zeros  = lead_zeros(s1_hash_q);
    assign s1_accept = (s1_zeros >= {1'b0, target_zeros});
    assign graded    = s1_valid_q && !flush;
    assign pop       = res.res_valid && res.res_ready;
    assign push      = graded && s1_accept && (!fifo_full || pop);
    assign drop      = graded && s1_accept && fifo_full && !pop;

    assign push_data.nonce = s1_nonce_q;
    assign push_data.zeros = s1_zeros;
    assign push_data.hash  = s1_hash_q;

    // Saturating statistics and the sticky overflow flag.
    always_comb begin
        acc_d  = acc_q;
        rej_d  = rej_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (graded && s1_accept && (acc_q != '1)) begin
            acc_d = acc_q + CNT_W'(1);
        end
        if (graded && !s1_accept && (rej_q != '1)) begin
            rej_d = rej_q + CNT_W'(1);
        end
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + 16'd1;
        end
        if (flush) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Statistics registers; flush leaves the counters alone.
    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            rej_q  <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            rej_q  <= rej_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
        end
    end

    bm1387_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_100m),
        .rst     (reset),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (push_data),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign res.res_valid = !fifo_empty;
    assign res.res_nonce = head.nonce;
    assign res.res_zeros = head.zeros;
    assign res.res_hash  = head.hash;

    assign shares_accepted = acc_q;
    assign shares_rejected = rej_q;
    assign shares_dropped  = drop_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_bm1387_result_collector.sv
module tb_bm1387_result_collector;
    import bm1387_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 6;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic          clk_100m = 1'b0;
    logic          reset = 1'b1;
    logic          hash_valid = 1'b0;
    logic [31:0]   found_nonce = '0;
    logic [255:0]  found_hash = '0;
    logic [7:0]    target_zeros = '0;
    logic          flush = 1'b0;
    logic [CW-1:0]    fifo_count;
    logic [CNT_W-1:0] shares_accepted;
    logic [CNT_W-1:0] shares_rejected;
    logic [15:0]      shares_dropped;
    logic             overflow;

    bm1387_result_collector_if res_if();

    bm1387_result_collector #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_100m        (clk_100m),
        .reset           (reset),
        .hash_valid      (hash_valid),
        .found_nonce     (found_nonce),
        .found_hash      (found_hash),
        .target_zeros    (target_zeros),
        .flush           (flush),
        .res             (res_if),
        .fifo_count      (fifo_count),
        .shares_accepted (shares_accepted),
        .shares_rejected (shares_rejected),
        .shares_dropped  (shares_dropped),
        .overflow        (overflow)
    );

    always #5 clk_100m = ~clk_100m;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of shares plus counters, stepped once per edge.
    bit             m_prev_hv;
    logic [31:0]    m_last_nonce;
    bit             m_pend;
    logic [31:0]    m_pn;
    logic [255:0]   m_ph;
    bm1387_result_t m_q[$];
    int             m_acc, m_rej, m_drop;
    bit             m_ovf;

    function automatic int ref_zeros(input logic [255:0] h);
        int z = 0;
        while (z < 256 && h[255 - z] == 1'b0) z++;
        return z;
    endfunction

    task automatic model_reset();
        m_prev_hv = 0; m_last_nonce = '0; m_pend = 0; m_pn = '0; m_ph = '0;
        m_q.delete(); m_acc = 0; m_rej = 0; m_drop = 0; m_ovf = 0;
    endtask

    task automatic model_step();
        bit             pop;
        bit             ev;
        int             z;
        bm1387_result_t r;
        pop = (m_q.size() > 0) && (res_if.res_ready === 1'b1);
        if (flush) begin
            m_q.delete();
            m_ovf = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_pend) begin
                z = ref_zeros(m_ph);
                if (z >= int'(target_zeros)) begin
                    if (m_acc < MAXC) m_acc++;
                    if (m_q.size() < DEPTH) begin
                        r.nonce = m_pn; r.zeros = 9'(z); r.hash = m_ph;
                        m_q.push_back(r);
                    end else begin
                        if (m_drop < 65535) m_drop++;
                        m_ovf = 1;
                    end
                end else begin
                    if (m_rej < MAXC) m_rej++;
                end
            end
        end
        ev = hash_valid && (!m_prev_hv || found_nonce != m_last_nonce);
        m_pend = ev && !flush;
        if (ev) begin
            m_pn = found_nonce; m_ph = found_hash; m_last_nonce = found_nonce;
        end
        m_prev_hv = hash_valid;
    endtask

    task automatic tick();
        @(posedge clk_100m);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        hash_valid = 0; flush = 0; res_if.res_ready = 0; target_zeros = 0;
        reset = 1;
        #2;
        model_reset();
        reset = 0;
        tick();
    endtask

    task automatic test_reset();
        res_if.res_ready = 0;
        reset = 1;
        #2;
        checks++; if (res_if.res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", res_if.res_valid); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        checks++; if ({shares_accepted, shares_rejected, shares_dropped, overflow} !== '0) begin errors++; $display("FAIL reset_counters got %0h exp 0", {shares_accepted, shares_rejected, shares_dropped, overflow}); end
        checks++; if ({res_if.res_nonce, res_if.res_zeros, res_if.res_hash} !== '0) begin errors++; $display("FAIL reset_head got nonzero head exp 0"); end
        model_reset();
        reset = 0;
        tick();
    endtask

    task automatic test_hold_single();
        do_reset();
        target_zeros = 8; found_nonce = 32'h1000; found_hash = 256'hFF << 240; hash_valid = 1;
        tick();
        checks++; if (res_if.res_valid !== 1'b0) begin errors++; $display("FAIL hold_latency1 got %0b exp 0", res_if.res_valid); end
        tick();
        checks++; if (res_if.res_valid !== 1'b1) begin errors++; $display("FAIL hold_latency2 got %0b exp 1", res_if.res_valid); end
        for (int i = 0; i < 8; i++) tick();
        checks++; if (fifo_count !== CW'(1)) begin errors++; $display("FAIL hold_count got %0d exp 1", fifo_count); end
        checks++; if (res_if.res_zeros !== 9'd8) begin errors++; $display("FAIL hold_zeros got %0d exp 8", res_if.res_zeros); end
        checks++; if (res_if.res_nonce !== 32'h1000) begin errors++; $display("FAIL hold_nonce got %0h exp 1000", res_if.res_nonce); end
        checks++; if (shares_accepted !== CNT_W'(1)) begin errors++; $display("FAIL hold_accepted got %0d exp 1", shares_accepted); end
        hash_valid = 0;
        tick();
    endtask

    task automatic test_reject_and_zero();
        do_reset();
        target_zeros = 8; found_nonce = 32'h1100; found_hash = 256'h01 << 248; hash_valid = 1;
        tick(); tick(); tick();
        checks++; if (shares_rejected !== CNT_W'(1)) begin errors++; $display("FAIL reject_count got %0d exp 1", shares_rejected); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reject_fifo got %0d exp 0", fifo_count); end
        checks++; if (shares_accepted !== '0) begin errors++; $display("FAIL reject_accepted got %0d exp 0", shares_accepted); end
        hash_valid = 0;
        tick();
        target_zeros = 255; found_nonce = 32'h1101; found_hash = '0; hash_valid = 1;
        tick(); tick();
        hash_valid = 0;
        checks++; if (res_if.res_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %0b exp 1", res_if.res_valid); end
        checks++; if (res_if.res_zeros !== 9'd256) begin errors++; $display("FAIL zero_zeros got %0d exp 256", res_if.res_zeros); end
        checks++; if (shares_accepted !== CNT_W'(1)) begin errors++; $display("FAIL zero_accepted got %0d exp 1", shares_accepted); end
        tick();
    endtask

    task automatic test_overflow_drain();
        do_reset();
        target_zeros = 0; found_hash = 256'h1234; hash_valid = 1;
        for (int i = 0; i < 10; i++) begin
            found_nonce = 32'h2000 + i;
            tick();
        end
        hash_valid = 0;
        tick(); tick();
        checks++; if (fifo_count !== CW'(8)) begin errors++; $display("FAIL ovf_count got %0d exp 8", fifo_count); end
        checks++; if (shares_dropped !== 16'd2) begin errors++; $display("FAIL ovf_dropped got %0d exp 2", shares_dropped); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
        checks++; if (shares_accepted !== CNT_W'(10)) begin errors++; $display("FAIL ovf_accepted got %0d exp 10", shares_accepted); end
        res_if.res_ready = 1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (res_if.res_valid !== 1'b1 || res_if.res_nonce !== 32'h2000 + i) begin errors++; $display("FAIL drain_nonce[%0d] got v=%0b %0h exp v=1 %0h", i, res_if.res_valid, res_if.res_nonce, 32'h2000 + i); end
            tick();
        end
        checks++; if (res_if.res_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b exp 0", res_if.res_valid); end
        res_if.res_ready = 0;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        target_zeros = 0; found_hash = 256'h55; hash_valid = 1;
        for (int i = 0; i < 8; i++) begin
            found_nonce = 32'h3000 + i;
            tick();
        end
        found_nonce = 32'h3008;
        tick();
        res_if.res_ready = 1; hash_valid = 0;
        tick();
        res_if.res_ready = 0;
        checks++; if (fifo_count !== CW'(8)) begin errors++; $display("FAIL fullpp_count got %0d exp 8", fifo_count); end
        checks++; if (shares_dropped !== '0 || overflow !== 1'b0) begin errors++; $display("FAIL fullpp_drop got %0d/%0b exp 0/0", shares_dropped, overflow); end
        checks++; if (res_if.res_nonce !== 32'h3001) begin errors++; $display("FAIL fullpp_head got %0h exp 3001", res_if.res_nonce); end
        checks++; if (shares_accepted !== CNT_W'(9)) begin errors++; $display("FAIL fullpp_accepted got %0d exp 9", shares_accepted); end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        target_zeros = 0; found_hash = 256'h77; hash_valid = 1;
        for (int i = 0; i < 4; i++) begin
            found_nonce = 32'h4000 + i;
            tick();
        end
        hash_valid = 0;
        tick();
        found_nonce = 32'h4004; hash_valid = 1;
        tick();
        flush = 1;
        tick();
        flush = 0;
        checks++; if (res_if.res_valid !== 1'b0 || fifo_count !== '0) begin errors++; $display("FAIL flush_fifo got v=%0b c=%0d exp 0/0", res_if.res_valid, fifo_count); end
        checks++; if (shares_accepted !== CNT_W'(4)) begin errors++; $display("FAIL flush_accepted got %0d exp 4", shares_accepted); end
        tick(); tick(); tick();
        checks++; if (fifo_count !== '0 || shares_accepted !== CNT_W'(4)) begin errors++; $display("FAIL flush_s1_discard got c=%0d a=%0d exp 0/4", fifo_count, shares_accepted); end
        hash_valid = 0;
        tick();
        // Force an overflow, then confirm flush clears the flag but not the drop count.
        hash_valid = 1;
        for (int i = 0; i < 9; i++) begin
            found_nonce = 32'h4100 + i;
            tick();
        end
        hash_valid = 0;
        tick(); tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_pre_ovf got %0b exp 1", overflow); end
        flush = 1;
        tick();
        flush = 0;
        checks++; if (overflow !== 1'b0 || shares_dropped !== 16'd1) begin errors++; $display("FAIL flush_ovf got o=%0b d=%0d exp 0/1", overflow, shares_dropped); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        target_zeros = 0; found_nonce = 32'h5000; found_hash = 256'h99; hash_valid = 1;
        tick(); tick();
        checks++; if (fifo_count !== CW'(1)) begin errors++; $display("FAIL rmid_pre got %0d exp 1", fifo_count); end
        #2 reset = 1;
        #1;
        checks++; if (res_if.res_valid !== 1'b0 || fifo_count !== '0 || shares_accepted !== '0 || res_if.res_nonce !== '0) begin errors++; $display("FAIL rmid_clear got v=%0b c=%0d a=%0d n=%0h exp all 0", res_if.res_valid, fifo_count, shares_accepted, res_if.res_nonce); end
        model_reset();
        #1 reset = 0;
        tick();
        checks++; if (res_if.res_valid !== 1'b0) begin errors++; $display("FAIL rmid_lat got %0b exp 0", res_if.res_valid); end
        tick();
        checks++; if (res_if.res_valid !== 1'b1 || res_if.res_nonce !== 32'h5000 || shares_accepted !== CNT_W'(1)) begin errors++; $display("FAIL rmid_recapture got v=%0b n=%0h a=%0d exp 1/5000/1", res_if.res_valid, res_if.res_nonce, shares_accepted); end
        hash_valid = 0;
        tick();
    endtask

    task automatic test_random();
        logic [255:0]   h;
        bm1387_result_t e;
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            hash_valid = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 2) != 0) found_nonce = 32'h6000 + $urandom_range(0, 3);
            for (int w = 0; w < 8; w++) h[w*32 +: 32] = $urandom;
            if ($urandom_range(0, 15) == 0) h = '0;
            else h = h >> $urandom_range(0, 30);
            found_hash = h;
            target_zeros = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 24));
            res_if.res_ready = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 29) == 0);
            tick();
            e = (m_q.size() > 0) ? m_q[0] : '0;
            checks++; if (res_if.res_valid !== (m_q.size() > 0) || fifo_count !== CW'(m_q.size())) begin errors++; $display("FAIL rand_occ[%0d] got v=%0b c=%0d exp v=%0b c=%0d", cyc, res_if.res_valid, fifo_count, m_q.size() > 0, m_q.size()); end
            checks++; if (res_if.res_nonce !== e.nonce || res_if.res_zeros !== e.zeros || res_if.res_hash !== e.hash) begin errors++; $display("FAIL rand_head[%0d] got n=%0h z=%0d exp n=%0h z=%0d", cyc, res_if.res_nonce, res_if.res_zeros, e.nonce, e.zeros); end
            checks++; if (shares_accepted !== CNT_W'(m_acc) || shares_rejected !== CNT_W'(m_rej)) begin errors++; $display("FAIL rand_counts[%0d] got a=%0d r=%0d exp a=%0d r=%0d", cyc, shares_accepted, shares_rejected, m_acc, m_rej); end
            checks++; if (shares_dropped !== 16'(m_drop) || overflow !== m_ovf) begin errors++; $display("FAIL rand_drop[%0d] got d=%0d o=%0b exp d=%0d o=%0b", cyc, shares_dropped, overflow, m_drop, m_ovf); end
        end
        flush = 0; hash_valid = 0; res_if.res_ready = 0;
        checks++; if (m_acc != MAXC || shares_accepted !== CNT_W'(MAXC)) begin errors++; $display("FAIL rand_saturate got a=%0d model=%0d exp %0d", shares_accepted, m_acc, MAXC); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        res_if.res_ready = 0;
        model_reset();
        test_reset();
        test_hold_single();
        test_reject_and_zero();
        test_overflow_drain();
        test_full_push_pop();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
